// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
//
// EX stage of the five-stage MIPS pipeline. Selects forwarded operands,
// runs the single-cycle ALU, resolves branch/jump decisions and target,
// and owns the EX/MEM pipeline register feeding the memory stage. A
// 32-iteration shift-add multiplier handles ALUControlE == 3'b111. While it
// runs, BusyE stalls the front end and EX/MEM is filled with bubbles.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   RegWriteE .. ALUSrcE           decoded controls of the EX instruction
//   ALUControlE[2:0]               add/sub/and/or/xor/slt/-/mul
//   RD1E, RD2E, ImmExtE            register operands, extended immediate
//   PCE, PCPlus4E                  PC and PC+4 of the EX instruction
//   RdE[4:0]                       destination register
//   ForwardAE, ForwardBE [1:0]     00 reg file, 01 ResultW, 10 ALU_ResultMem
//   ResultW                        writeback value for forwarding
//   FlushE                         kill the EX instruction (and any multiply)
//   RegWrtMem, MemWrtMem,
//   ResultSrcMem, RD_Mem,
//   PCplus4Mem, WriteDataMem,
//   ALU_ResultMem                  EX/MEM register outputs
//   PCTargetE, PCSrcE              branch target and taken decision (comb)
//   BusyE                          multiplier occupancy (comb)
// ---------------------------------------------------------------------------
module execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic        ResultSrcE,
  input  logic        BranchE,
  input  logic        JumpE,
  input  logic        ALUSrcE,
  input  logic [2:0]  ALUControlE,
  input  logic [31:0] RD1E,
  input  logic [31:0] RD2E,
  input  logic [31:0] ImmExtE,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RdE,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ResultW,
  input  logic        FlushE,
  output logic        RegWrtMem,
  output logic        MemWrtMem,
  output logic        ResultSrcMem,
  output logic [4:0]  RD_Mem,
  output logic [31:0] PCplus4Mem,
  output logic [31:0] WriteDataMem,
  output logic [31:0] ALU_ResultMem,
  output logic [31:0] PCTargetE,
  output logic        PCSrcE,
  output logic        BusyE
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

  // EX/MEM register
  logic        reg_write_mem_reg;
  logic        mem_write_mem_reg;
  logic        result_src_mem_reg;
  logic [4:0]  rd_mem_reg;
  logic [31:0] pc_plus4_mem_reg;
  logic [31:0] write_data_mem_reg;
  logic [31:0] alu_result_mem_reg;

  // Multiplier state
  mul_state_t  state_reg, state_next;
  logic [31:0] mcand_reg;
  logic [31:0] mplier_reg;
  logic [31:0] acc_reg;
  logic [4:0]  count_reg;

  // Combinational datapath
  logic [31:0] src_a;
  logic [31:0] write_data;
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic        zero;
  logic        is_mul;

  // FSM outputs
  logic        mul_start;
  logic        load_bubble;
  logic        take_product;
  logic        busy;

  // -------------------------------------------------------------------------
  // Operand forwarding; select 11 falls back to the register-file value.
  // -------------------------------------------------------------------------
  always_comb begin
    unique case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = alu_result_mem_reg;
      default: src_a = RD1E;
    endcase
  end

  always_comb begin
    unique case (ForwardBE)
      2'b01:   write_data = ResultW;
      2'b10:   write_data = alu_result_mem_reg;
      default: write_data = RD2E;
    endcase
  end

  assign src_b  = ALUSrcE ? ImmExtE : write_data;
  assign is_mul = (ALUControlE == OP_MUL);

  // -------------------------------------------------------------------------
  // Single-cycle ALU. The mul code yields 0 here; the product only ever
  // comes from the accumulator, so it never feeds the zero flag.
  // -------------------------------------------------------------------------
  always_comb begin
    alu_result = 32'd0;
    unique case (ALUControlE)
      OP_ADD:  alu_result = src_a + src_b;
      OP_SUB:  alu_result = src_a - src_b;
      OP_AND:  alu_result = src_a & src_b;
      OP_OR:   alu_result = src_a | src_b;
      OP_XOR:  alu_result = src_a ^ src_b;
      OP_SLT:  alu_result = {31'd0, ($signed(src_a) < $signed(src_b))};
      default: alu_result = 32'd0;
    endcase
  end

  assign zero      = (alu_result == 32'd0);
  assign PCTargetE = PCE + ImmExtE;
  assign PCSrcE    = ~is_mul & ((BranchE & zero) | JumpE);

  // -------------------------------------------------------------------------
  // Multiplier FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Multiplier FSM: next state. Flush wins over both start and completion.
  always_comb begin
    state_next = state_reg;
    if (FlushE) begin
      state_next = ST_IDLE;
    end else begin
      unique case (state_reg)
        ST_IDLE: if (is_mul) state_next = ST_BUSY;
        ST_BUSY: if (count_reg == 5'd31) state_next = ST_DONE;
        ST_DONE: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Multiplier FSM: outputs
  always_comb begin
    mul_start    = 1'b0;
    load_bubble  = 1'b0;
    take_product = 1'b0;
    busy         = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        mul_start   = is_mul & ~FlushE;
        busy        = is_mul & ~FlushE & ~rst;
        load_bubble = is_mul;
      end
      ST_BUSY: begin
        busy        = 1'b1;
        load_bubble = 1'b1;
      end
      ST_DONE: begin
        take_product = 1'b1;
      end
      default: begin
        load_bubble = 1'b1;
      end
    endcase
    if (FlushE) begin
      load_bubble  = 1'b1;
      take_product = 1'b0;
    end
  end

  assign BusyE = busy;

  // -------------------------------------------------------------------------
  // Shift-add datapath. Operands are captured at start so forwarding changes
  // while the ID/EX register is stalled cannot disturb the product. Only the
  // low 32 bits matter, so bits shifted out of the multiplicand are dropped.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_reg  <= 32'd0;
      mplier_reg <= 32'd0;
      acc_reg    <= 32'd0;
      count_reg  <= 5'd0;
    end else if (mul_start) begin
      mcand_reg  <= src_a;
      mplier_reg <= src_b;
      acc_reg    <= 32'd0;
      count_reg  <= 5'd0;
    end else if (state_reg == ST_BUSY) begin
      if (mplier_reg[0]) begin
        acc_reg <= acc_reg + mcand_reg;
      end
      mcand_reg  <= {mcand_reg[30:0], 1'b0};
      mplier_reg <= {1'b0, mplier_reg[31:1]};
      count_reg  <= count_reg + 5'd1;
    end
  end

  // -------------------------------------------------------------------------
  // EX/MEM pipeline register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || load_bubble) begin
      reg_write_mem_reg  <= 1'b0;
      mem_write_mem_reg  <= 1'b0;
      result_src_mem_reg <= 1'b0;
      rd_mem_reg         <= 5'd0;
      pc_plus4_mem_reg   <= 32'd0;
      write_data_mem_reg <= 32'd0;
      alu_result_mem_reg <= 32'd0;
    end else begin
      reg_write_mem_reg  <= RegWriteE;
      mem_write_mem_reg  <= MemWriteE;
      result_src_mem_reg <= ResultSrcE;
      rd_mem_reg         <= RdE;
      pc_plus4_mem_reg   <= PCPlus4E;
      write_data_mem_reg <= write_data;
      alu_result_mem_reg <= take_product ? acc_reg : alu_result;
    end
  end

  assign RegWrtMem     = reg_write_mem_reg;
  assign MemWrtMem     = mem_write_mem_reg;
  assign ResultSrcMem  = result_src_mem_reg;
  assign RD_Mem        = rd_mem_reg;
  assign PCplus4Mem    = pc_plus4_mem_reg;
  assign WriteDataMem  = write_data_mem_reg;
  assign ALU_ResultMem = alu_result_mem_reg;

endmodule
